water_level_tracker: RTL and testbench
======================================

// Module: water_level_tracker
// PURPOSE
//   Parametrised successor to the 3-bit level FSM. Tracks tank water level as a saturating
//   up/down counter driven by the "upper" float sensor. Adds input synchronisation/debounce,
//   a step-enable prescaler for drip mode (no gated/muxed clocks), trend FSM and hysteresis
//   alarms. Sits between the raw sensor pins and the irrigation scheduler FSM.
// PARAMETERS
//   LEVEL_W          3   width of level output
//   MAX_LEVEL        7   saturation ceiling; must be <= 2**LEVEL_W-1
//   LOW_THRESH       1   low_alarm sets when level <= LOW_THRESH
//   HIGH_THRESH      6   high_alarm sets when level >= HIGH_THRESH
//   HYST             2   alarm release distance; LOW_THRESH+HYST <= HIGH_THRESH-HYST
//   DEBOUNCE_CYCLES  4   consecutive differing samples needed to accept new sensor value (>=1)
//   DRIP_DIV         8   clock cycles per level step in drip mode (>=2)
//   FAULT_STEPS      16  step count for stuck-sensor watchdog (used only with macro)
// PORTS
//   clock        in   1        system clock
//   reset        in   1        asynchronous, active-high
//   upper        in   1        raw float sensor, asynchronous; 1 = water rising
//   dripper      in   1        1 = drip mode (step every DRIP_DIV cycles), 0 = step every cycle
//   level        out  LEVEL_W  current level, 0..MAX_LEVEL
//   trend        out  2        FSM state: EMPTY / FILLING / DRAINING / FULL
//   empty        out  1        level == 0
//   full         out  1        level == MAX_LEVEL
//   low_alarm    out  1        hysteretic low-level flag
//   high_alarm   out  1        hysteretic high-level flag
//   changed      out  1        one-cycle pulse on the edge after level changes
//   fault        out  1        sticky stuck-sensor flag (constant 0 without macro)
// BEHAVIOUR
//   Reset (async): level=0, trend=EMPTY, empty=1, full=0, low_alarm=1, high_alarm=0,
//     changed=0, fault=0; synchroniser, debounce counter, prescaler, watchdog cleared; stable=0.
//   Sync: upper -> 2-FF synchroniser -> sync_upper.
//   Debounce: if sync_upper != stable, cnt++; on the edge where cnt reaches DEBOUNCE_CYCLES-1
//     while still differing, stable<=sync_upper, cnt<=0. Any equal sample clears cnt.
//     A held raw change is accepted after 2+DEBOUNCE_CYCLES edges.
//   Step: dripper=0 -> step every cycle, div_cnt held 0. dripper=1 -> div_cnt counts
//     0..DRIP_DIV-1, step on DRIP_DIV-1 then wraps. Any dripper edge zeroes div_cnt.
//   Level on step: stable=1 and level<MAX_LEVEL -> +1; stable=0 and level>0 -> -1;
//     else hold (saturate, never wrap). Step uses stable as registered before the edge,
//     so a same-edge stable flip affects the next step only.
//   FSM (updates with level): EMPTY (level 0); FILLING (last move +1, level<MAX);
//     DRAINING (last move -1, level>0); FULL (level MAX). Held level keeps state.
//   Alarms, registered and evaluated on the new level: low_alarm sets at <=LOW_THRESH,
//     clears at >=LOW_THRESH+HYST; high_alarm sets at >=HIGH_THRESH, clears at
//     <=HIGH_THRESH-HYST; otherwise hold. All flags are aligned with level, no extra lag.
//   changed: high for exactly one cycle, aligned with the new level value.
//   Reset mid-operation: immediate return to reset values; no partial step is retained.
// CONFIGURATION
//   `WATER_LEVEL_FAULT_EN defined: count steps where level==MAX_LEVEL and stable==1, or
//     level==0 and stable==0; any other step clears the count. At FAULT_STEPS the module
//     sets fault, which is sticky until reset. Level behaviour is unchanged.
//   Not defined: no watchdog logic; fault tied to 0.
// STRUCTURE
//   Package irrigation_pkg: trend_t enum (EMPTY=2'd0, FILLING=2'd1, DRAINING=2'd2,
//     FULL=2'd3) and shared default constants for DEBOUNCE_CYCLES and DRIP_DIV.
//   Sub-module level_debouncer (synchroniser + debounce counter, parameter DEBOUNCE_CYCLES).
//   Top holds the prescaler, level counter, FSM, alarms and optional watchdog.
// TESTING
//   1. Defaults, dripper=0, upper=1 held: level 0->7 one per cycle after 6-cycle debounce
//      lag; saturates at 7; full=1, trend=FULL, high_alarm set at level 6; changed pulses 7 times.
//   2. From 7, upper=0: level steps down; high_alarm clears at 4; low_alarm sets at 1;
//      at 0 empty=1 and trend=EMPTY; no wrap to 7.
//   3. upper glitch of 3 cycles (< DEBOUNCE_CYCLES): stable and level unchanged, changed=0.
//   4. dripper=1, upper=1: level increments exactly every 8 cycles; toggling dripper
//      mid-count restarts the 8-cycle interval.
//   5. Assert reset at level 5 mid-fill: next sample shows level=0, low_alarm=1, trend=EMPTY;
//      after release, counting resumes only after the full debounce lag.
//   6. With WATER_LEVEL_FAULT_EN: hold upper=1 at level 7 for 16 steps -> fault=1,
//      stays 1 after upper=0; clears only on reset. Without the macro fault stays 0.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared types and default constants for the irrigation control blocks.
package irrigation_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        DRAINING = 2'd2,
        FULL     = 2'd3
    } trend_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_DRIP_DIV        = 8;

endpackage

// File: rtl/level_debouncer.sv
// Two-flop synchroniser followed by a debounce counter for the float sensor.
// A held raw change appears on stable_o after 2+DEBOUNCE_CYCLES clock edges.
module level_debouncer
    import irrigation_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: every register here uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            if (sync_q != stable_q) begin
                if (cnt_q == CNT_LAST) begin
                    stable_q <= sync_q;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/water_level_tracker.sv
// Saturating tank-level tracker with drip prescaler, trend FSM and hysteretic alarms.
// Define WATER_LEVEL_FAULT_EN to build the sticky stuck-sensor watchdog.
module water_level_tracker
    import irrigation_pkg::*;
#(
    parameter int LEVEL_W         = 3,
    parameter int MAX_LEVEL       = 7,
    parameter int LOW_THRESH      = 1,
    parameter int HIGH_THRESH     = 6,
    parameter int HYST            = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int DRIP_DIV        = DEFAULT_DRIP_DIV,
    parameter int FAULT_STEPS     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               upper,
    input  logic               dripper,
    output logic [LEVEL_W-1:0] level,
    output logic [1:0]         trend,
    output logic               empty,
    output logic               full,
    output logic               low_alarm,
    output logic               high_alarm,
    output logic               changed,
    output logic               fault
);

    localparam int                 DIV_W    = $clog2(DRIP_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DRIP_DIV - 1);
    localparam logic [LEVEL_W-1:0] MAX_L    = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] LOW_SET  = LEVEL_W'(LOW_THRESH);
    localparam logic [LEVEL_W-1:0] LOW_CLR  = LEVEL_W'(LOW_THRESH + HYST);
    localparam logic [LEVEL_W-1:0] HIGH_SET = LEVEL_W'(HIGH_THRESH);
    localparam logic [LEVEL_W-1:0] HIGH_CLR = LEVEL_W'(HIGH_THRESH - HYST);

    if (MAX_LEVEL > (2 ** LEVEL_W) - 1 || DEBOUNCE_CYCLES < 1 || DRIP_DIV < 2 ||
        FAULT_STEPS < 1 || LOW_THRESH + HYST > HIGH_THRESH - HYST) begin : g_bad_params
        $error("water_level_tracker: inconsistent parameters");
    end

    logic               stable;
    logic               step;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    trend_t             trend_q, trend_d;
    logic               low_q, low_d;
    logic               high_q, high_d;
    logic               empty_q, full_q, changed_q;

    level_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
        .clock   (clock),
        .reset   (reset),
        .raw_i   (upper),
        .stable_o(stable)
    );

    // NOTE: each always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        step    = !dripper || (div_q == DIV_LAST);
        div_d   = '0;
        level_d = level_q;
        trend_d = trend_q;
        low_d   = low_q;
        high_d  = high_q;

        if (dripper && div_q != DIV_LAST) begin
            div_d = div_q + DIV_W'(1);
        end

        if (step) begin
            if (stable && level_q < MAX_L) begin
                level_d = level_q + LEVEL_W'(1);
                trend_d = FILLING;
            end else if (!stable && level_q != '0) begin
                level_d = level_q - LEVEL_W'(1);
                trend_d = DRAINING;
            end
        end
        if (level_d == '0)        trend_d = EMPTY;
        else if (level_d == MAX_L) trend_d = FULL;

        // Alarms look at the level being loaded so they stay aligned with it.
        if (level_d <= LOW_SET)       low_d = 1'b1;
        else if (level_d >= LOW_CLR)  low_d = 1'b0;
        if (level_d >= HIGH_SET)      high_d = 1'b1;
        else if (level_d <= HIGH_CLR) high_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            level_q   <= '0;
            trend_q   <= EMPTY;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            low_q     <= 1'b1;
            high_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            level_q   <= level_d;
            trend_q   <= trend_d;
            empty_q   <= (level_d == '0);
            full_q    <= (level_d == MAX_L);
            low_q     <= low_d;
            high_q    <= high_d;
            changed_q <= (level_d != level_q);
        end
    end

`ifdef WATER_LEVEL_FAULT_EN
    localparam int              FCNT_W    = $clog2(FAULT_STEPS + 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FAULT_STEPS - 1);

    logic [FCNT_W-1:0] fcnt_q;
    logic              fault_q;
    logic              stuck;

    // Sensor keeps pushing against a rail the level can no longer move past.
    assign stuck = (level_q == MAX_L && stable) || (level_q == '0 && !stable);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fcnt_q  <= '0;
            fault_q <= 1'b0;
        end else if (step) begin
            if (!stuck) begin
                fcnt_q <= '0;
            end else if (fcnt_q == FCNT_LAST) begin
                fault_q <= 1'b1;
            end else begin
                fcnt_q <= fcnt_q + FCNT_W'(1);
            end
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign level      = level_q;
    assign trend      = trend_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign low_alarm  = low_q;
    assign high_alarm = high_q;
    assign changed    = changed_q;

endmodule

// File: tb/tb_water_level_tracker.sv
// Directed bench for water_level_tracker: vector table plus hand-written multi-cycle sequences.
module tb_water_level_tracker;
    import irrigation_pkg::*;

`ifdef WATER_LEVEL_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       upper;
    logic       dripper;
    logic [2:0] level;
    logic [1:0] trend;
    logic       empty, full, low_alarm, high_alarm, changed, fault;

    typedef struct {
        logic        upper;
        logic        dripper;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    water_level_tracker dut (
        .clock     (clock),
        .reset     (reset),
        .upper     (upper),
        .dripper   (dripper),
        .level     (level),
        .trend     (trend),
        .empty     (empty),
        .full      (full),
        .low_alarm (low_alarm),
        .high_alarm(high_alarm),
        .changed   (changed),
        .fault     (fault)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] pk(input int lvl, input trend_t tr, input bit emp, input bit fl,
                                       input bit lo, input bit hi, input bit ch);
        return {3'(lvl), tr, emp, fl, lo, hi, ch, 1'b0};
    endfunction

    function automatic logic [10:0] outs();
        return {level, trend, empty, full, low_alarm, high_alarm, changed, fault};
    endfunction

    task automatic add(input bit u, input logic [10:0] exp, input int rep = 1);
        vec_t v;
        v.upper   = u;
        v.dripper = 1'b0;
        v.exp     = exp;
        for (int i = 0; i < rep; i++) vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int exp_lvl;
        int prev_lvl;

        // Fill from empty: six idle edges of debounce lag, then one step per edge to 7.
        add(1, pk(0, EMPTY, 1, 0, 1, 0, 0), 6);
        add(1, pk(1, FILLING, 0, 0, 1, 0, 1));
        add(1, pk(2, FILLING, 0, 0, 1, 0, 1));
        add(1, pk(3, FILLING, 0, 0, 0, 0, 1));
        add(1, pk(4, FILLING, 0, 0, 0, 0, 1));
        add(1, pk(5, FILLING, 0, 0, 0, 0, 1));
        add(1, pk(6, FILLING, 0, 0, 0, 1, 1));
        add(1, pk(7, FULL,    0, 1, 0, 1, 1));
        add(1, pk(7, FULL,    0, 1, 0, 1, 0), 2);
        // Drain to empty, then saturate at 0.
        add(0, pk(7, FULL,     0, 1, 0, 1, 0), 6);
        add(0, pk(6, DRAINING, 0, 0, 0, 1, 1));
        add(0, pk(5, DRAINING, 0, 0, 0, 1, 1));
        add(0, pk(4, DRAINING, 0, 0, 0, 0, 1));
        add(0, pk(3, DRAINING, 0, 0, 0, 0, 1));
        add(0, pk(2, DRAINING, 0, 0, 0, 0, 1));
        add(0, pk(1, DRAINING, 0, 0, 1, 0, 1));
        add(0, pk(0, EMPTY,    1, 0, 1, 0, 1));
        add(0, pk(0, EMPTY,    1, 0, 1, 0, 0), 2);
        // Three-cycle glitch is rejected by the debouncer.
        add(1, pk(0, EMPTY, 1, 0, 1, 0, 0), 3);
        add(0, pk(0, EMPTY, 1, 0, 1, 0, 0), 4);

        reset   = 1'b1;
        upper   = 1'b0;
        dripper = 1'b0;
        repeat (2) tick();
        check("reset_state", 16'(outs()), 16'(pk(0, EMPTY, 1, 0, 1, 0, 0)));
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            upper   = vecs[i].upper;
            dripper = vecs[i].dripper;
            tick();
            check($sformatf("vec%0d", i), 16'(outs()), 16'(vecs[i].exp));
        end

        // Drip mode: one step per 8 edges; a one-cycle dripper drop steps once and restarts the interval.
        upper    = 1'b1;
        prev_lvl = 0;
        for (int f = 1; f <= 37; f++) begin
            dripper = (f != 29);
            tick();
            if (f <= 28)      exp_lvl = f / 8;
            else if (f < 37)  exp_lvl = 4;
            else              exp_lvl = 5;
            check($sformatf("drip_level_%0d", f), 16'(level), 16'(exp_lvl));
            check($sformatf("drip_changed_%0d", f), 16'(changed), 16'(exp_lvl != prev_lvl));
            prev_lvl = exp_lvl;
        end

        // Asynchronous reset at level 5, observed before the next clock edge.
        reset = 1'b1;
        #2;
        check("async_reset", {10'd0, level, trend, low_alarm}, {10'd0, 3'd0, EMPTY, 1'b1});
        check("async_reset_changed", 16'(changed), 16'd0);
        tick();
        reset   = 1'b0;
        dripper = 1'b0;
        upper   = 1'b1;

        // Refill after the full debounce lag, then hold at 7 long enough to trip the watchdog.
        for (int g = 1; g <= 29; g++) begin
            tick();
            exp_lvl = (g <= 6) ? 0 : ((g - 6 > 7) ? 7 : g - 6);
            check($sformatf("refill_level_%0d", g), 16'(level), 16'(exp_lvl));
            check($sformatf("fault_%0d", g), 16'(fault), 16'(FAULT_EN && g >= 29));
        end
        upper = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("fault_sticky_%0d", k), 16'(fault), 16'(FAULT_EN));
        end
        reset = 1'b1;
        #2;
        check("fault_reset", 16'(fault), 16'd0);
        check("fault_reset_level", 16'(level), 16'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
